// File: rtl/uart_pkg.sv
// UART definitions shared by the transmitter and receiver.
package uart_pkg;

    localparam int WORD_SIZE   = 8;
    localparam int PULSE_WIDTH = 868;
    localparam int PACKET_SIZE = WORD_SIZE + 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/transmitter_if.sv
// Valid/ready word handshake between the user logic and the UART transmitter.
interface transmitter_if #(
    parameter int WORD_SIZE = uart_pkg::WORD_SIZE
) ();

    logic [WORD_SIZE-1:0] data_in;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output data_in, output tx_valid, input  tx_ready);
    modport slave  (input  data_in, input  tx_valid, output tx_ready);

endinterface

// File: rtl/transmitter_baud_counter.sv
// Bit-period counter: counts 0..PULSE_WIDTH-1 while enabled and ticks on the terminal count.
module baud_counter #(
    parameter int PULSE_WIDTH = uart_pkg::PULSE_WIDTH
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(PULSE_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(PULSE_WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start bit, WORD_SIZE data bits LSB first, stop bit, with a
// one-word holding buffer so consecutive frames follow with no idle gap.
module transmitter #(
    parameter int WORD_SIZE   = uart_pkg::WORD_SIZE,
    parameter int PULSE_WIDTH = uart_pkg::PULSE_WIDTH,
    parameter int PACKET_SIZE = uart_pkg::PACKET_SIZE
) (
    input  logic         clk,
    input  logic         rstn,
    transmitter_if.slave tx_if,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done
);

    import uart_pkg::*;

    if (PACKET_SIZE != WORD_SIZE + 2) begin : g_bad_packet_size
        $error("transmitter: PACKET_SIZE must equal WORD_SIZE+2");
    end
    if (PULSE_WIDTH < 2) begin : g_bad_pulse_width
        $error("transmitter: PULSE_WIDTH must be at least 2");
    end

    localparam int            BW       = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

    tx_state_t            state, state_n;
    logic [WORD_SIZE-1:0] shifter, shifter_n, hold;
    logic                 hold_full;
    logic [BW-1:0]        bit_cnt;
    logic                 accept, tick, tx_n;
    logic                 load_in, load_hold, shift, bit_clr, bit_inc;

    assign tx_if.tx_ready = !hold_full;
    assign accept         = tx_if.tx_valid && !hold_full;
    assign tx_busy        = (state != IDLE);
    assign tx_done        = (state == STOP) && tick;

    baud_counter #(.PULSE_WIDTH(PULSE_WIDTH)) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (load_in || load_hold),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_in   = 1'b0;
        load_hold = 1'b0;
        shift     = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n   = START;
                    load_hold = 1'b1;
                end else if (accept) begin
                    state_n = START;
                    load_in = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = STOP;
                    else                     bit_inc = 1'b1;
                end
            end
            STOP: begin
                // A word arriving on the final stop cycle skips the buffer to keep frames gapless.
                if (tick) begin
                    if (hold_full) begin
                        state_n   = START;
                        load_hold = 1'b1;
                    end else if (accept) begin
                        state_n = START;
                        load_in = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        shifter_n = shifter;
        if (load_hold)    shifter_n = hold;
        else if (load_in) shifter_n = tx_if.data_in;
        else if (shift)   shifter_n = shifter >> 1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shifter_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // tx is registered from next-state values so it changes on the acceptance edge itself.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
        end else begin
            shifter <= shifter_n;
            tx      <= tx_n;
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);
            if (load_hold) begin
                hold_full <= 1'b0;
            end else if (accept && !load_in) begin
                hold      <= tx_if.data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Scoreboard bench for the UART transmitter: a sampling receiver model decodes
// the line and compares each frame with words recorded at acceptance.
module tb_transmitter;

    localparam int WS    = 8;
    localparam int PW    = 4;
    localparam int PS    = 10;
    localparam int FRAME = PS * PW;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic tx, tx_busy, tx_done;

    transmitter_if #(.WORD_SIZE(WS)) tif ();

    transmitter #(
        .WORD_SIZE   (WS),
        .PULSE_WIDTH (PW),
        .PACKET_SIZE (PS)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tx_if   (tif.slave),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    logic [WS-1:0] expq [$];
    int            done_q [$];
    bit   in_frame = 1'b0;
    int   idx = 0;
    logic samp [FRAME];

    logic [WS-1:0] words [10] = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF,
                                  8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic decode_frame();
        logic [WS-1:0] w;
        bit shape_ok;
        shape_ok = 1'b1;
        for (int b = 0; b < PS; b++)
            for (int j = 1; j < PW; j++)
                if (samp[b*PW+j] !== samp[b*PW]) shape_ok = 1'b0;
        check("bit_shape", 32'(shape_ok), 1);
        check("start_bit", 32'(samp[0]), 0);
        check("stop_bit", 32'(samp[FRAME-1]), 1);
        for (int b = 0; b < WS; b++) w[b] = samp[(b+1)*PW];
        if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_word: got 0x%0h, expected no frame", w);
        end else begin
            check("rx_word", 32'(w), 32'(expq.pop_front()));
        end
    endtask

    // Receiver model: one sample per clock, a frame is FRAME samples from the falling start edge.
    always @(negedge clk) begin
        if (!rstn) begin
            in_frame = 1'b0;
            idx      = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                idx      = 0;
            end
            check("tx_busy", 32'(tx_busy), 32'(in_frame));
            if (in_frame) begin
                samp[idx] = tx;
                check("tx_done", 32'(tx_done), 32'(idx == FRAME - 1));
                if (tx_done === 1'b1) done_q.push_back(cyc);
                idx++;
                if (idx == FRAME) begin
                    decode_frame();
                    in_frame = 1'b0;
                end
            end else begin
                check("idle_tx", 32'(tx), 1);
                check("idle_done", 32'(tx_done), 0);
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; tx_ready is stable until the next edge.
    task automatic send(input logic [WS-1:0] w, input bit keep);
        bit ok, rdy;
        ok = 1'b0;
        tif.data_in  = w;
        tif.tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rdy = tif.tx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            expq.push_back(w);
            acc_cyc = cyc;
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: word 0x%0h not accepted, required acceptance within 200 cycles", w);
        end
        if (!keep) tif.tx_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!tx_busy && tif.tx_ready && !in_frame && expq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick_n(1);
        end
        check("drain", 32'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        tif.tx_valid = 1'b0;
        tif.data_in  = '0;
        #1 rstn = 1'b0;
        #2;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_ready", 32'(tif.tx_ready), 1);
        check("rst_done", 32'(tx_done), 0);
        tick_n(3);
        rstn = 1'b1;
        tick_n(3);

        // Single word from idle: tx_done on the 40th cycle after acceptance.
        done_q.delete();
        send(8'h55, 1'b0);
        wait_quiet();
        check("t1_done_count", 32'(done_q.size()), 1);
        if (done_q.size() >= 1) check("t1_done_latency", 32'(done_q[0] - acc_cyc), FRAME - 1);

        // Back-to-back with valid held: second word buffered, frames gapless.
        done_q.delete();
        send(8'hA3, 1'b1);
        acc0 = acc_cyc;
        send(8'h7E, 1'b0);
        check("t2_ready_low", 32'(tif.tx_ready), 0);
        wait_quiet();
        check("t2_done_count", 32'(done_q.size()), 2);
        if (done_q.size() >= 2) begin
            check("t2_done0", 32'(done_q[0] - acc0), FRAME - 1);
            check("t2_done1", 32'(done_q[1] - acc0), 2 * FRAME - 1);
        end

        // All-zero and all-one words with idle gaps.
        send(8'h00, 1'b0);
        wait_quiet();
        tick_n(5);
        send(8'hFF, 1'b0);
        wait_quiet();

        // Reset during data bit 3 of 0xC3 (bit value 0) aborts the frame at once.
        send(8'hC3, 1'b0);
        tick_n(17);
        check("t4_pre_tx", 32'(tx), 0);
        rstn = 1'b0;
        #1;
        check("t4_rst_tx", 32'(tx), 1);
        check("t4_rst_busy", 32'(tx_busy), 0);
        check("t4_rst_ready", 32'(tif.tx_ready), 1);
        check("t4_rst_done", 32'(tx_done), 0);
        expq.delete();
        tick_n(2);
        rstn = 1'b1;
        tick_n(3);
        done_q.delete();
        send(8'h81, 1'b0);
        wait_quiet();
        check("t4_done_count", 32'(done_q.size()), 1);

        // Random data_in with valid high while the buffer holds 0x3C must not be taken.
        send(8'h11, 1'b0);
        send(8'h3C, 1'b0);
        check("t5_ready_low", 32'(tif.tx_ready), 0);
        tif.tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tif.tx_ready) break;
            tif.data_in = WS'($urandom);
            tick_n(1);
        end
        tif.tx_valid = 1'b0;
        wait_quiet();

        // Loopback of ten words with random gaps.
        done_q.delete();
        for (int i = 0; i < 10; i++) begin
            send(words[i], 1'b0);
            tick_n(int'($urandom_range(1, 50)));
        end
        wait_quiet();
        check("t6_done_count", 32'(done_q.size()), 10);

        tick_n(20);
        check("final_queue", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
- UART serial transmitter: the transmit-side counterpart of the existing receiver.
- Accepts parallel words through a valid/ready handshake and serialises each one onto a single line, LSB first: 1 start bit (0), WORD_SIZE data bits, 1 stop bit (1).
- A one-word holding buffer allows back-to-back frames with no idle gap.
- Sits between the user logic / command path and the board TX pin; looped back to the receiver in system tests.

Parameters:
- WORD_SIZE, 8, data bits per frame.
- PULSE_WIDTH, 868, clock cycles per bit (CLOCK_FREQ/BAUD; 100 MHz / 115200). Must be >= 2.
- PACKET_SIZE, 10, bits per frame (start + word + stop). Must equal WORD_SIZE+2; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- data_in  input  WORD_SIZE  word to transmit.
- tx_valid  input  1  data_in is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  a frame is on the line.
- tx_done  output  1  one-cycle pulse on the last cycle of a stop bit.

Behaviour:
- Reset (async, rstn=0): tx=1, tx_ready=1, tx_busy=0, tx_done=0; FSM=IDLE; counters=0; holding buffer empty.
  - Reset asserted mid-frame aborts the frame and drives tx high immediately. No partial frame resumes after reset release.
- Handshake:
  - A word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready = !buffer_full, registered-equivalent. It does not depend combinationally on tx_valid.
  - data_in is sampled only at acceptance. Changes while tx_ready=0 have no effect.
- Buffer:
  - A one-word holding register. The shifter loads from it.
  - If the FSM is IDLE at acceptance, the word bypasses the buffer straight into the shifter.
- FSM states and transitions:
  - IDLE: tx=1. On acceptance (or buffer non-empty) -> START. Load shifter at that same edge.
  - START: tx=0 for PULSE_WIDTH cycles -> DATA.
  - DATA: tx=shifter[0] for PULSE_WIDTH cycles per bit. Shift right after each bit. bit_cnt counts 0..WORD_SIZE-1; after bit WORD_SIZE-1 -> STOP.
  - STOP: tx=1 for PULSE_WIDTH cycles. On the final cycle, tx_done=1.
    - If the buffer is full: load shifter from the buffer, clear the buffer, -> START. The next start bit follows with zero idle cycles.
    - Otherwise -> IDLE.
- Timing:
  - tx falls at the clock edge of acceptance (visible in the following cycle).
  - Frame length is exactly PACKET_SIZE*PULSE_WIDTH cycles.
  - tx_busy=1 in START/DATA/STOP.
- Baud counter: counts 0..PULSE_WIDTH-1, cleared on entry to START, with a tick on the terminal count. Width $clog2(PULSE_WIDTH).
- Simultaneous events:
  - Acceptance during the final STOP cycle with the buffer empty: the word goes directly to the shifter (no buffer hop), so frames stay gapless.
  - Acceptance with the buffer full is impossible, since tx_ready=0.
- Idle: tx remains 1 indefinitely. No spurious tx_done.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, STOP}.
  - Default constants WORD_SIZE, PULSE_WIDTH, PACKET_SIZE, shared with the receiver.
- Sub-module baud_counter: parameter PULSE_WIDTH; inputs clk, rstn, clear, enable; output tick. Reusable by the receiver.

Test Plan (PULSE_WIDTH=4, WORD_SIZE=8; frame = 40 cycles):
- Single word 0x55 after reset -> tx pattern 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. tx_done pulses 40 cycles after acceptance. Looped-back receiver gives data_bits=0x55, rx_valid=1.
- tx_valid held high with 0xA3 then 0x7E -> 0x7E accepted while 0xA3 shifts. tx_ready is low until the 0xA3 stop-bit load. Both frames total 80 cycles with no idle cycle between them. Receiver gets 0xA3 then 0x7E.
- 0x00 then 0xFF with idle gaps -> first frame has tx low for 36 consecutive cycles then high for 4. Second frame has tx low for exactly 4 cycles (start only).
- rstn driven low during data bit 3 of 0xC3 -> tx=1, tx_busy=0, tx_ready=1 without waiting for a clock edge. After release, 0x81 transmits correctly and the receiver gets 0x81 with no corrupt word.
- data_in toggled randomly while tx_ready=0 with 0x3C buffered -> the transmitted second word is exactly 0x3C.
- Loopback of 0x55, 0xA3, 0x7E, 0x00, 0xFF, 0xC3, 0x3C, 0x5A, 0x81, 0x1E with random 1–50 cycle gaps -> the receiver reproduces all 10 words in order, and tx_done count = 10.
